// File: rtl/cordic_vec_post.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_vec_post
//  Description : Output stage of the CORDIC vectoring pipeline. Rebuilds the
//                angle from the micro-rotation decision bits by summing an
//                arctangent table one term per cycle. It then applies the
//                quadrant correction and the 1/K gain compensation, and
//                presents (magnitude, angle) on a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_vec_post #(
    parameter int data_width   = 16,
    parameter int cordic_steps = 16,
    parameter int GAIN_Q15     = 19898
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   x_vec_in,
    input  logic [cordic_steps-1:0] micro_rotation_in,
    input  logic [1:0]              quad_in,
    output logic [data_width-1:0]   mag_out,
    output logic [data_width-1:0]   angle_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overflow
);

    localparam int IDX_W = (cordic_steps > 1) ? $clog2(cordic_steps) : 1;
    // The product needs data_width + 16 bits for a Q1.15 gain. One spare
    // bit keeps the sign safe.
    localparam int PW    = data_width + 17;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] CORR  = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    localparam logic [data_width-1:0] QUARTER  = data_width'(1) << (data_width - 2);
    localparam logic signed [PW-1:0]  GAIN_EXT = PW'(GAIN_Q15);

    // Table entry i is round(atan(2^-i) * 2^(data_width-1) / pi).
    // It is evaluated once, at elaboration time.
    function automatic logic [data_width-1:0] atan_term(input int i);
        real v;
        v = $atan(1.0 / (2.0 ** i)) * (2.0 ** (data_width - 1)) / 3.14159265358979323846;
        return data_width'($rtoi(v + 0.5));
    endfunction

    logic [data_width-1:0]   lut [cordic_steps];

    for (genvar gi = 0; gi < cordic_steps; gi++) begin : g_lut
        assign lut[gi] = atan_term(gi);
    end

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [data_width-1:0]   acc;
    logic [data_width-1:0]   x_reg;
    logic [cordic_steps-1:0] micro_reg;
    logic [1:0]              quad_reg;

    logic [data_width-1:0]   lut_term;
    logic [data_width-1:0]   acc_next;
    logic [data_width-1:0]   offset;
    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    prod;
    logic [data_width-1:0]   mag_next;
    logic                    last_term;

    assign in_ready  = (state == IDLE);
    assign last_term = (idx == IDX_W'(cordic_steps - 1));

    // Add the current arctangent term when the micro-rotation went
    // positive, and subtract it otherwise. The sum wraps modulo 2^data_width.
    always_comb begin
        lut_term = lut[idx];
        acc_next = micro_reg[idx] ? (acc + lut_term) : (acc - lut_term);
    end

    // Map the quadrant code to the angle offset. Code 11 is reserved and
    // adds nothing.
    always_comb begin
        offset = '0;
        case (quad_reg)
            2'b01:   offset = QUARTER;
            2'b10:   offset = data_width'(0) - QUARTER;
            default: offset = '0;
        endcase
    end

    // Apply the gain compensation: take the full signed product, shift it
    // arithmetically by 15, and truncate to data_width.
    always_comb begin
        x_ext    = PW'($signed(x_reg));
        prod     = x_ext * GAIN_EXT;
        mag_next = data_width'(prod >>> 15);
    end

    // Main sequencer: accept, then accumulate, then correct, then hold the
    // output until it is taken.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            x_reg     <= '0;
            micro_reg <= '0;
            quad_reg  <= '0;
            mag_out   <= '0;
            angle_out <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x_vec_in;
                        micro_reg <= micro_rotation_in;
                        quad_reg  <= quad_in;
                        acc       <= '0;
                        idx       <= '0;
                        state     <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    idx <= idx + IDX_W'(1);
                    if (last_term) begin
                        state <= CORR;
                    end
                end
                CORR: begin
                    angle_out <= acc + offset;
                    mag_out   <= mag_next;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag. Upstream has no backpressure, so any input that
    // arrives while busy is lost and is recorded here.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow <= 1'b0;
        end else if (in_valid && (state != IDLE)) begin
            overflow <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cordic_vec_post.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_vec_post
//  Description : Self-checking bench for cordic_vec_post. It drives one
//                4-step instance and one default 16-step instance, and uses
//                a scoreboard queue per instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_vec_post;

    typedef struct {
        logic [15:0] mag;
        logic [15:0] ang;
    } exp_t;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  micro;
        logic [1:0]  quad;
        logic [15:0] mag;
        logic [15:0] ang;
    } vec_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, overflow4;
    logic [15:0] x4 = '0, mag4, ang4;
    logic [3:0]  micro4 = '0;
    logic [1:0]  quad4 = '0;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b1, overflow16;
    logic [15:0] x16 = '0, mag16, ang16;
    logic [15:0] micro16 = '0;
    logic [1:0]  quad16 = '0;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q4[$];
    exp_t q16[$];

    always #5 clk = ~clk;

    cordic_vec_post #(.data_width(16), .cordic_steps(4), .GAIN_Q15(19898)) dut4 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid4), .in_ready(in_ready4),
        .x_vec_in(x4), .micro_rotation_in(micro4), .quad_in(quad4),
        .mag_out(mag4), .angle_out(ang4), .out_valid(out_valid4),
        .out_ready(out_ready4), .overflow(overflow4)
    );

    cordic_vec_post dut16 (
        .clk(clk), .nreset(nreset), .in_valid(in_valid16), .in_ready(in_ready16),
        .x_vec_in(x16), .micro_rotation_in(micro16), .quad_in(quad16),
        .mag_out(mag16), .angle_out(ang16), .out_valid(out_valid16),
        .out_ready(out_ready16), .overflow(overflow16)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference arctangent table for a 16-bit angle.
    function automatic logic [15:0] atan_ref(input int i);
        real v;
        v = $atan(1.0 / (2.0 ** i)) * 32768.0 / 3.141592653589793;
        return 16'($rtoi(v + 0.5));
    endfunction

    function automatic logic [15:0] angle_model16(input logic [15:0] micro, input logic [1:0] quad);
        logic [15:0] a;
        a = 16'd0;
        for (int i = 0; i < 16; i++) begin
            if (micro[i]) a = a + atan_ref(i);
            else          a = a - atan_ref(i);
        end
        if (quad == 2'b01) a = a + 16'h4000;
        if (quad == 2'b10) a = a - 16'h4000;
        return a;
    endfunction

    function automatic logic [15:0] mag_model(input logic signed [15:0] x);
        longint p;
        p = longint'(x) * 19898;
        return 16'(p >>> 15);
    endfunction

    // Compare each delivered result against the oldest expectation.
    always @(negedge clk) begin
        if (nreset && out_valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                check("spurious_out4", out_valid4, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("mag4", mag4, e.mag);
                check("angle4", ang4, e.ang);
            end
        end
        if (nreset && out_valid16 && out_ready16) begin
            if (q16.size() == 0) begin
                check("spurious_out16", out_valid16, 0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("mag16", mag16, e.mag);
                check("angle16", ang16, e.ang);
            end
        end
    end

    task automatic wait_valid16(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (out_valid16) break;
        end
        check("out_valid16_arrives", out_valid16, 1);
    endtask

    task automatic apply4(input vec_t v, input string name);
        int lat;
        for (int t = 0; t < 50 && !in_ready4; t++) begin
            @(posedge clk); #1;
        end
        check({name, "_ready"}, in_ready4, 1);
        in_valid4 = 1'b1; x4 = v.x; micro4 = v.micro; quad4 = v.quad;
        q4.push_back('{mag: v.mag, ang: v.ang});
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid4) break;
        end
        check({name, "_latency"}, lat, 5);
        @(posedge clk); #1;
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'd1000,  4'b1111, 2'b00, 16'd607,   16'd16880};
        vecs[1] = '{16'd1000,  4'b0001, 2'b00, 16'd607,   16'hFE10};
        vecs[2] = '{16'd1000,  4'b0001, 2'b01, 16'd607,   16'd15888};
        vecs[3] = '{16'd1000,  4'b0001, 2'b10, 16'd607,   16'hBE10};
        vecs[4] = '{16'd1000,  4'b0001, 2'b11, 16'd607,   16'hFE10};
        vecs[5] = '{16'd1000,  4'b1111, 2'b01, 16'd607,   16'h81F0};
        vecs[6] = '{16'hFC18,  4'b0000, 2'b00, 16'hFDA0,  16'hBE10};
        vecs[7] = '{16'h7FFF,  4'b1010, 2'b00, 16'd19897, 16'hEDFA};
        vecs[8] = '{16'h8000,  4'b0110, 2'b10, 16'hB246,  16'hB7CE};

        // Hold reset with in_valid asserted; nothing may be accepted.
        nreset = 1'b0; in_valid4 = 1'b1; in_valid16 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mag4", mag4, 0);
        check("rst_angle4", ang4, 0);
        check("rst_valid4", out_valid4, 0);
        check("rst_ovf4", overflow4, 0);
        check("rst_mag16", mag16, 0);
        check("rst_valid16", out_valid16, 0);
        check("rst_ovf16", overflow16, 0);
        in_valid4 = 1'b0; in_valid16 = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        @(negedge clk);
        check("rst_ready4", in_ready4, 1);
        check("rst_ready16", in_ready16, 1);

        // Table-driven 4-step vectors.
        for (int i = 0; i < 9; i++) begin
            apply4(vecs[i], $sformatf("vec%0d", i));
        end

        // Default instance: back-pressure holds the result stable.
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        in_valid16 = 1'b1; x16 = 16'd16384; micro16 = 16'hA5C3; quad16 = 2'b01;
        q16.push_back('{mag: 16'd9949, ang: angle_model16(16'hA5C3, 2'b01)});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        wait_valid16(40);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check("stall_mag", mag16, 9949);
            check("stall_angle", ang16, angle_model16(16'hA5C3, 2'b01));
            check("stall_valid", out_valid16, 1);
            check("stall_in_ready", in_ready16, 0);
        end
        @(posedge clk); #1;
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("release_valid", out_valid16, 0);
        check("release_in_ready", in_ready16, 1);

        // A second input during ACCUM is dropped and flagged.
        @(posedge clk); #1;
        in_valid16 = 1'b1; x16 = 16'hEC78; micro16 = 16'h3C5A; quad16 = 2'b10;
        q16.push_back('{mag: mag_model(16'hEC78), ang: angle_model16(16'h3C5A, 2'b10)});
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid16 = 1'b1; x16 = 16'd123; micro16 = 16'h0000; quad16 = 2'b00;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        @(negedge clk);
        check("ovf_set", overflow16, 1);
        check("ovf_dut4_clean", overflow4, 0);
        wait_valid16(40);
        @(posedge clk); #1;
        @(negedge clk);
        check("ovf_sticky", overflow16, 1);
        check("ovf_idle", in_ready16, 1);

        // Reset in the middle of ACCUM discards the operation.
        @(posedge clk); #1;
        in_valid16 = 1'b1; x16 = 16'd500; micro16 = 16'hFFFF; quad16 = 2'b00;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        nreset = 1'b0;
        @(negedge clk);
        check("midrst_valid", out_valid16, 0);
        @(posedge clk); #1;
        nreset = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            check("midrst_no_output", out_valid16, 0);
        end
        check("midrst_idle", in_ready16, 1);
        check("midrst_ovf_cleared", overflow16, 0);

        check("q4_drained", q4.size(), 0);
        check("q16_drained", q16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
